// File: rtl/alu_seq.sv
// Sequencer for an external 16-bit ALU, with an 8x16 register file and a carry flag.
// Latency: ALU ops respond 2 cycles after accept; LOADI/READ/reserved respond 1 cycle after accept.
// Backpressure: one command in flight; cmd_ready drops until the response is taken with res_ready.
module alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs1,
  input  logic [2:0]  cmd_rs2,
  input  logic [15:0] cmd_imm,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_o,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_cout,
  output logic        res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_LOADI = 3'b100;
  localparam logic [2:0] OP_READ  = 3'b101;

  state_t      state_q, state_d;
  logic [15:0] regs_q [8];
  logic        carry_q;
  logic [15:0] a_q, b_q;
  logic [1:0]  op_q;
  logic [2:0]  rd_q;
  logic [15:0] res_data_q;
  logic        res_cout_q, res_err_q;

  logic        accept;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [15:0] rf_wd;

  // A command is taken only in IDLE and never while reset is high.
  assign accept = cmd_valid && (state_q == IDLE) && !reset;

  // Operands and op are held in latches so the ALU sees them for the whole EXEC cycle.
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign res_data = res_data_q;
  assign res_cout = res_cout_q;
  assign res_err  = res_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; ALU opcodes have bit 2 clear.
  always_comb begin
    state_d   = state_q;
    cmd_ready = (state_q == IDLE) && !reset;
    res_valid = (state_q == RESP) && !reset;
    case (state_q)
      IDLE: if (accept) state_d = cmd_op[2] ? RESP : EXEC;
      EXEC: state_d = RESP;
      RESP: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single register-file write port: LOADI at accept, ALU result at the end of EXEC.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 3'd0;
    rf_wd = 16'd0;
    if (accept && cmd_op == OP_LOADI) begin
      rf_we = 1'b1;
      rf_wa = cmd_rd;
      rf_wd = cmd_imm;
    end else if (state_q == EXEC) begin
      rf_we = 1'b1;
      rf_wa = rd_q;
      rf_wd = alu_o;
    end
  end

  // Register file; reset wins over an in-flight EXEC write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 16'd0;
    end else if (rf_we) begin
      regs_q[rf_wa] <= rf_wd;
    end
  end

  // Operand latches, carry flag and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q    <= 1'b0;
      a_q        <= 16'd0;
      b_q        <= 16'd0;
      op_q       <= 2'd0;
      rd_q       <= 3'd0;
      res_data_q <= 16'd0;
      res_cout_q <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        // Operands are captured before any write, so rd may alias rs1/rs2.
        a_q  <= regs_q[cmd_rs1];
        b_q  <= regs_q[cmd_rs2];
        op_q <= cmd_op[1:0];
        rd_q <= cmd_rd;
        case (cmd_op)
          OP_LOADI: begin
            res_data_q <= cmd_imm;
            res_cout_q <= carry_q;
            res_err_q  <= 1'b0;
          end
          OP_READ: begin
            res_data_q <= regs_q[cmd_rs1];
            res_cout_q <= carry_q;
            res_err_q  <= 1'b0;
          end
          3'b110, 3'b111: begin
            res_data_q <= 16'd0;
            res_cout_q <= carry_q;
            res_err_q  <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state_q == EXEC) begin
        carry_q    <= alu_cout;
        res_data_q <= alu_o;
        res_cout_q <= alu_cout;
        res_err_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: models the external ALU and checks responses against a register-file model.
// Directed scenarios, backpressure, mid-EXEC reset and randomized command streams.
// Inputs driven on the falling edge or just after the rising edge; outputs sampled on the falling edge.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op, cmd_rd, cmd_rs1, cmd_rs2;
  logic [15:0] cmd_imm;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_o;
  logic        alu_cout;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_cout, res_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: register contents and carry flag as the commands define them.
  logic [15:0] m_regs [8];
  logic        m_carry;

  alu_seq dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    int s;
    s = 0;
    alu_o    = 16'd0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: begin s = int'(alu_a) + int'(alu_b); alu_o = s[15:0]; alu_cout = (s > 65535); end
      2'b01: begin alu_o = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
      2'b10: alu_o = alu_a & alu_b;
      default: alu_o = alu_a | alu_b;
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
    m_carry = 1'b0;
  endtask

  // Issue one command, check latency, operands and response, hold the response for
  // 'hold' cycles, then release it and update the model.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [15:0] imm, input int hold);
    logic [15:0] a, b, e_data;
    logic        e_cout, e_err, is_alu;
    int          e_lat, lat, s;
    a = m_regs[rs1];
    b = m_regs[rs2];
    is_alu = (op <= 3'd3);
    e_lat  = is_alu ? 2 : 1;
    e_err  = 1'b0;
    e_cout = m_carry;
    e_data = 16'd0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); e_data = s[15:0]; e_cout = (s > 65535); end
      3'd1: begin e_data = a - b; e_cout = (a >= b); end
      3'd2: begin e_data = a & b; e_cout = 1'b0; end
      3'd3: begin e_data = a | b; e_cout = 1'b0; end
      3'd4: e_data = imm;
      3'd5: e_data = a;
      default: e_err = 1'b1;
    endcase

    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready_before_issue: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_op = $urandom_range(0, 7); cmd_rs1 = $urandom_range(0, 7); cmd_imm = $urandom;

    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && is_alu) begin
        n_tests++;
        if (alu_op !== op[1:0] || alu_a !== a || alu_b !== b) begin
          n_fail++;
          $display("FAIL exec_operands op=%0d: got op=%b a=%h b=%h want op=%b a=%h b=%h",
                   op, alu_op, alu_a, alu_b, op[1:0], a, b);
        end
      end
      if (res_valid === 1'b1 || lat > 8) break;
    end
    n_tests++;
    if (lat !== e_lat) begin
      n_fail++; $display("FAIL latency op=%0d: got %0d want %0d", op, lat, e_lat);
    end
    n_tests++;
    if (res_data !== e_data || res_cout !== e_cout || res_err !== e_err) begin
      n_fail++;
      $display("FAIL response op=%0d rd=%0d rs1=%0d rs2=%0d: got data=%h cout=%b err=%b want data=%h cout=%b err=%b",
               op, rd, rs1, rs2, res_data, res_cout, res_err, e_data, e_cout, e_err);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || res_data !== e_data || res_cout !== e_cout || res_err !== e_err) begin
        n_fail++;
        $display("FAIL hold_stable cyc=%0d: got vld=%b rdy=%b data=%h want vld=1 rdy=0 data=%h",
                 h, res_valid, cmd_ready, res_data, e_data);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;

    if (op == 3'd4) m_regs[rd] = imm;
    else if (is_alu) begin m_regs[rd] = e_data; m_carry = e_cout; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL in_reset_handshake: got rdy=%b vld=%b want 0 0", cmd_ready, res_valid);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 16'd0 || res_cout !== 1'b0 ||
        res_err !== 1'b0 || alu_a !== 16'd0 || alu_b !== 16'd0 || alu_op !== 2'd0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got rdy=%b vld=%b data=%h cout=%b err=%b a=%h b=%h op=%b want rdy=1 rest 0",
               cmd_ready, res_valid, res_data, res_cout, res_err, alu_a, alu_b, alu_op);
    end
    for (int i = 0; i < 8; i++) do_cmd(3'd5, 3'd0, 3'(i), 3'd0, 16'd0, 0);
  endtask

  task automatic test_directed();
    do_cmd(3'd4, 3'd1, 3'd0, 3'd0, 16'h0005, 0);
    do_cmd(3'd4, 3'd2, 3'd0, 3'd0, 16'h0003, 0);
    do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 16'h0000, 0);
    do_cmd(3'd5, 3'd0, 3'd3, 3'd0, 16'h0000, 0);
    do_cmd(3'd1, 3'd4, 3'd1, 3'd2, 16'h0000, 0);
    do_cmd(3'd1, 3'd4, 3'd2, 3'd1, 16'h0000, 0);
    do_cmd(3'd4, 3'd5, 3'd0, 3'd0, 16'hFFFF, 0);
    do_cmd(3'd4, 3'd6, 3'd0, 3'd0, 16'h0001, 0);
    do_cmd(3'd0, 3'd5, 3'd5, 3'd6, 16'h0000, 0);
    do_cmd(3'd5, 3'd0, 3'd5, 3'd0, 16'h0000, 0);
    do_cmd(3'd4, 3'd1, 3'd0, 3'd0, 16'hF0F0, 0);
    do_cmd(3'd4, 3'd2, 3'd0, 3'd0, 16'h0FF0, 0);
    do_cmd(3'd2, 3'd3, 3'd1, 3'd2, 16'h0000, 0);
    do_cmd(3'd3, 3'd4, 3'd1, 3'd2, 16'h0000, 0);
    do_cmd(3'd6, 3'd1, 3'd1, 3'd2, 16'h1234, 0);
    do_cmd(3'd7, 3'd2, 3'd1, 3'd2, 16'h5678, 0);
    for (int i = 0; i < 8; i++) do_cmd(3'd5, 3'd0, 3'(i), 3'd0, 16'd0, 0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_rd = 3'd7; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0; cmd_imm = 16'h1234;
    @(posedge clk);
    #1 cmd_op = 3'd5; cmd_rs1 = 3'd7; cmd_imm = 16'h0000;
    m_regs[7] = 16'h1234;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      n_tests++;
      if (res_valid !== 1'b1 || res_data !== 16'h1234 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d: got vld=%b data=%h rdy=%b want vld=1 data=1234 rdy=0",
                 h, res_valid, res_data, cmd_ready);
      end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_no_accept: got vld=%b rdy=%b want vld=0 rdy=1", res_valid, cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1 || res_data !== 16'h1234 || res_err !== 1'b0) begin
      n_fail++; $display("FAIL bp_held_cmd: got vld=%b data=%h want vld=1 data=1234", res_valid, res_data);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    do_cmd(3'd4, 3'd1, 3'd0, 3'd0, 16'h0011, 0);
    do_cmd(3'd4, 3'd2, 3'd0, 3'd0, 16'h0022, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_exec_in_reset: got vld=%b rdy=%b want 0 0", res_valid, cmd_ready);
    end
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_exec_idle: got rdy=%b vld=%b want 1 0", cmd_ready, res_valid);
    end
    do_cmd(3'd5, 3'd0, 3'd3, 3'd0, 16'd0, 0);
    do_cmd(3'd5, 3'd0, 3'd1, 3'd0, 16'd0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      do_cmd(3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 16'd0, 0);
      do_cmd(3'd4, 3'($urandom_range(0, 7)), 3'd0, 3'd0, 16'($urandom), 0);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = 3'd0; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0; cmd_imm = 16'd0;
    model_reset();
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 cmd_valid  input  1  command present.
REQ-004 cmd_ready  output  1  block can accept a command.
REQ-005 cmd_op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 LOADI, 101 READ, 110/111 reserved.
REQ-006 cmd_rd, cmd_rs1, cmd_rs2  input  3 each  destination and source register indices.
REQ-007 cmd_imm  input  16  LOADI immediate.
REQ-008 alu_op  output  2  op to the external 16-bit ALU: 00 add, 01 sub (carry-in 1), 10 and, 11 or.
REQ-009 alu_a, alu_b  output  16 each  ALU operands i0, i1.
REQ-010 alu_o  input  16  ALU result.
REQ-011 alu_cout  input  1  ALU carry out (for SUB, 1 = no borrow).
REQ-012 res_valid  output  1  response present.
REQ-013 res_ready  input  1  consumer accepts response.
REQ-014 res_data  output  16  result, immediate, or register value.
REQ-015 res_cout  output  1  carry flag after the command.
REQ-016 res_err  output  1  reserved opcode flagged.

Function
REQ-017 Block SHALL contain an 8 x 16-bit register file r0..r7 (all writable) and a 1-bit carry flag.
REQ-018 FSM SHALL have states IDLE, EXEC, RESP; cmd_ready SHALL equal (state==IDLE) and not reset.
REQ-019 Command SHALL be accepted on a rising edge with cmd_valid and cmd_ready both 1; all cmd_* fields SHALL be latched on that edge.
REQ-020 On acceptance, operand latches SHALL capture r[rs1] into A and r[rs2] into B, and opcode into a latched op.
REQ-021 On acceptance, ALU opcodes (000-011) SHALL transition IDLE->EXEC; LOADI, READ and reserved SHALL transition IDLE->RESP directly.
REQ-022 alu_a, alu_b, alu_op SHALL be driven continuously from the A, B and op[1:0] latches; only EXEC-cycle values are consumed.
REQ-023 On the edge ending EXEC: r[rd] <= alu_o, carry <= alu_cout, res_data <= alu_o, res_cout <= alu_cout, res_err <= 0; transition EXEC->RESP.
REQ-024 LOADI on acceptance SHALL write r[rd] <= cmd_imm and res_data <= cmd_imm; carry unchanged.
REQ-025 READ on acceptance SHALL set res_data <= r[rs1]; no register or carry write.
REQ-026 Reserved opcodes SHALL write nothing, set res_data <= 0 and res_err <= 1.
REQ-027 res_cout SHALL always reflect the carry flag value after the command completes.
REQ-028 res_valid SHALL be 1 exactly in RESP; res_data/res_cout/res_err SHALL be stable while res_valid=1 and res_ready=0.
REQ-029 RESP->IDLE SHALL occur on the edge with res_ready=1; no new command SHALL be accepted in that same cycle.
REQ-030 Latency: ALU op res_valid rises 2 cycles after the accept edge; LOADI/READ/reserved 1 cycle.
REQ-031 rd equal to rs1 or rs2 SHALL use pre-write operand values (latched at acceptance).
REQ-032 Arithmetic SHALL be modulo 2^16; overflow indicated only via carry.
REQ-033 cmd_valid while cmd_ready=0 SHALL be ignored; no state change.

Reset
REQ-034 While reset=1 on an edge: state <= IDLE, r0..r7 <= 0, carry <= 0, A/B/op latches <= 0, res_data <= 0, res_cout <= 0, res_err <= 0.
REQ-035 Reset SHALL override any state including mid-EXEC or mid-RESP; the in-flight command SHALL be dropped with no register write.
REQ-036 cmd_ready and res_valid SHALL read 0 while reset=1; cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-037 LOADI r1=0x0005, LOADI r2=0x0003, ADD r3,r1,r2 -> res_data=0x0008, res_cout=0, res_valid 2 cycles after accept; READ r3 -> 0x0008.
REQ-038 SUB r4,r1,r2 -> 0x0002, cout=1; SUB r4,r2,r1 -> 0xFFFE, cout=0; alu_op=01 during EXEC.
REQ-039 LOADI r5=0xFFFF, LOADI r6=0x0001, ADD r5,r5,r6 -> 0x0000, cout=1, READ r5 -> 0x0000.
REQ-040 r1=0xF0F0, r2=0x0FF0: AND -> 0x00F0, OR -> 0xFFF0; op 110 -> res_err=1, res_data=0, no register changed.
REQ-041 Hold res_ready=0 for 5 cycles in RESP -> res_valid and res_data stable, cmd_ready=0, held cmd_valid not accepted until cycle after res_ready=1.
REQ-042 Assert reset during EXEC of ADD r3 -> next cycle IDLE, res_valid=0, READ r3 after reset -> 0x0000.
